dfu_led_status: RTL

//  Parametrised LED status-pattern generator for TinyDFU boards.

---
 rtl/dfu_led_status.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dfu_led_status.sv
// LED status-pattern generator: off, on, blink, cylon sweep, progress fill and error flash.
// Optional macro LED_STATUS_BREATHE_EN turns BLINK into an 8-bit PWM breathing ramp.
module dfu_led_status #(
  parameter int NUM_LEDS      = 4,
  parameter int PRESCALE_BITS = 20,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [2:0]          mode,
  input  logic [7:0]          progress,
  output logic [NUM_LEDS-1:0] led,
  output logic                step
);

  localparam int POS_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LIT_W  = $clog2(NUM_LEDS + 2);
  localparam int PROD_W = 8 + LIT_W;

  localparam logic [NUM_LEDS-1:0] LED_UNLIT = (ACTIVE_LOW != 0) ? '1 : '0;

  localparam logic [2:0] MODE_ON    = 3'd1;
  localparam logic [2:0] MODE_BLINK = 3'd2;
  localparam logic [2:0] MODE_CYLON = 3'd3;
  localparam logic [2:0] MODE_FILL  = 3'd4;
  localparam logic [2:0] MODE_ERROR = 3'd5;

  logic [PRESCALE_BITS-1:0] prescaler_q;
  logic [2:0]               mode_q;
  logic [7:0]               progress_q;
  logic [POS_W-1:0]         pos_q;
  logic [POS_W-1:0]         pos_nxt;
  logic                     dir_down_q;
  logic                     dir_down_nxt;
  logic                     phase_q;
  logic                     restart;
  logic                     tick;
  logic                     blink_bit;
  logic [PROD_W-1:0]        fill_prod;
  logic [LIT_W-1:0]         fill_lvl;
  logic [NUM_LEDS-1:0]      lit_pat;

  // A mode change restarts the pattern and overrides any step on the same edge.
  assign restart = (mode != mode_q);
  assign tick    = (&prescaler_q) && !restart;

  always_comb begin
    pos_nxt      = pos_q;
    dir_down_nxt = dir_down_q;
    if (NUM_LEDS > 1) begin
      if (dir_down_q) pos_nxt = pos_q - POS_W'(1);
      else            pos_nxt = pos_q + POS_W'(1);
      // Direction flips on arrival at an end so the ends are not repeated.
      if (pos_nxt == POS_W'(NUM_LEDS - 1)) dir_down_nxt = 1'b1;
      else if (pos_nxt == '0)              dir_down_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescaler_q <= '0;
      mode_q      <= '0;
      pos_q       <= '0;
      dir_down_q  <= 1'b0;
      phase_q     <= 1'b0;
      step        <= 1'b0;
    end else begin
      mode_q <= mode;
      step   <= tick;
      if (restart) begin
        prescaler_q <= '0;
        pos_q       <= '0;
        dir_down_q  <= 1'b0;
        phase_q     <= 1'b0;
      end else begin
        prescaler_q <= prescaler_q + PRESCALE_BITS'(1);
        if (tick) begin
          phase_q    <= ~phase_q;
          pos_q      <= pos_nxt;
          dir_down_q <= dir_down_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    progress_q <= progress;
  end

`ifdef LED_STATUS_BREATHE_EN
  if (PRESCALE_BITS < 16) begin : g_prescale_check
    $error("LED_STATUS_BREATHE_EN needs PRESCALE_BITS >= 16");
  end

  logic [7:0] ramp;
  logic [7:0] duty;
  assign ramp      = prescaler_q[PRESCALE_BITS-1 -: 8];
  assign duty      = phase_q ? ~ramp : ramp;
  assign blink_bit = (prescaler_q[7:0] < duty);
`else
  assign blink_bit = phase_q;
`endif

  assign fill_prod = PROD_W'(progress_q) * PROD_W'(NUM_LEDS + 1);
  assign fill_lvl  = LIT_W'(fill_prod >> 8);

  always_comb begin
    lit_pat = '0;
    case (mode_q)
      MODE_ON:    lit_pat = '1;
      MODE_BLINK: lit_pat[0] = blink_bit;
      MODE_CYLON: begin
        for (int i = 0; i < NUM_LEDS; i++) lit_pat[i] = (POS_W'(i) == pos_q);
      end
      MODE_FILL: begin
        for (int i = 0; i < NUM_LEDS; i++) lit_pat[i] = (LIT_W'(i) < fill_lvl);
      end
      // Bit PRESCALE_BITS-2 flips on every fast tick; zero right after a restart.
      MODE_ERROR: lit_pat = {NUM_LEDS{~prescaler_q[PRESCALE_BITS-2]}};
      default:    lit_pat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) led <= LED_UNLIT;
    else         led <= (ACTIVE_LOW != 0) ? ~lit_pat : lit_pat;
  end

endmodule
